id_stage_pipe: RTL and testbench

//  Parametrised MIPS instruction-decode stage: decodes a 32-bit instruction, reads a REG_N x DATA_W register file,
//  and registers operands and control into an ID/EX pipeline register guarded by a valid/ready handshake.

---
 rtl/id_stage_pipe_pkg.sv | 37 +++
 rtl/id_regfile.sv | 39 +++
 rtl/id_stage_pipe.sv | 113 +++++++++++
 tb/tb_id_stage_pipe.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/id_stage_pipe_pkg.sv
// Shared MIPS opcode/funct constants and small decode helpers for the ID stage.
package id_stage_pipe_pkg;

  localparam logic [5:0] R_FORM = 6'h00;
  localparam logic [5:0] BEQ    = 6'h04;
  localparam logic [5:0] BNE    = 6'h05;
  localparam logic [5:0] ADDI   = 6'h08;
  localparam logic [5:0] ADDIU  = 6'h09;
  localparam logic [5:0] SLTI   = 6'h0A;
  localparam logic [5:0] ANDI   = 6'h0C;
  localparam logic [5:0] ORI    = 6'h0D;
  localparam logic [5:0] XORI   = 6'h0E;
  localparam logic [5:0] LUI    = 6'h0F;
  localparam logic [5:0] LW     = 6'h23;
  localparam logic [5:0] SW     = 6'h2B;

  localparam logic [5:0] ADD    = 6'h20;
  localparam logic [5:0] SUB    = 6'h22;
  localparam logic [5:0] AND    = 6'h24;
  localparam logic [5:0] OR     = 6'h25;
  localparam logic [5:0] XOR    = 6'h26;
  localparam logic [5:0] SLT    = 6'h2A;

  // Instructions that read rt as a source operand (all other I-forms write it).
  function automatic logic uses_rt(input logic [5:0] op);
    return (op == R_FORM) || (op == SW) || (op == BEQ) || (op == BNE);
  endfunction

  function automatic logic zero_ext(input logic [5:0] op);
    return (op == ANDI) || (op == ORI) || (op == XORI);
  endfunction

  function automatic logic no_writeback(input logic [5:0] op);
    return (op == SW) || (op == BEQ) || (op == BNE);
  endfunction

endpackage

// File: rtl/id_regfile.sv
// Register file: two combinational read ports, one write port, r0 hard-wired to zero.
module id_regfile #(
  parameter int DATA_W    = 32,
  parameter int REG_N     = 32,
  parameter bit BYPASS_EN = 1'b1,
  localparam int REG_AW   = $clog2(REG_N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr1,
  input  logic [REG_AW-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] regs [REG_N];

  // NOTE: this storage is cleared by reset, so it maps to flops rather than RAM macros.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_N; i++) regs[i] <= '0;
    end else if (we && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata1 = regs[raddr1];
    rdata2 = regs[raddr2];
    if (BYPASS_EN && we && waddr == raddr1) rdata1 = wdata;
    if (BYPASS_EN && we && waddr == raddr2) rdata2 = wdata;
    if (raddr1 == '0) rdata1 = '0;
    if (raddr2 == '0) rdata2 = '0;
  end

endmodule

// File: rtl/id_stage_pipe.sv
// MIPS instruction-decode stage: decode, register read with WB bypass, load-use
// bubble and flush, feeding a valid/ready ID/EX pipeline register.
module id_stage_pipe
  import id_stage_pipe_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int REG_N     = 32,
  parameter bit BYPASS_EN = 1'b1,
  localparam int REG_AW   = $clog2(REG_N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       ins,
  input  logic              flush,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic [DATA_W-1:0] imm,
  output logic [REG_AW-1:0] dest,
  output logic [5:0]        funct,
  output logic [4:0]        shamt,
  output logic [5:0]        op,
  output logic              mem_rd,
  output logic              reg_we
);

  logic [5:0]        op_d;
  logic [REG_AW-1:0] rs_a, rt_a, rd_a;
  logic [REG_AW-1:0] dest_d;
  logic [5:0]        funct_d;
  logic [DATA_W-1:0] imm_d;
  logic [DATA_W-1:0] rs_val, rt_val;
  logic              hazard, accept;

  assign op_d = ins[31:26];
  assign rs_a = ins[21 +: REG_AW];
  assign rt_a = ins[16 +: REG_AW];
  assign rd_a = ins[11 +: REG_AW];

  id_regfile #(
    .DATA_W    (DATA_W),
    .REG_N     (REG_N),
    .BYPASS_EN (BYPASS_EN)
  ) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .we     (wb_we),
    .waddr  (wb_addr),
    .wdata  (wb_data),
    .raddr1 (rs_a),
    .raddr2 (rt_a),
    .rdata1 (rs_val),
    .rdata2 (rt_val)
  );

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    dest_d  = rt_a;
    funct_d = '0;
    imm_d   = {{(DATA_W-16){ins[15]}}, ins[15:0]};
    if (op_d == R_FORM) begin
      dest_d  = rd_a;
      funct_d = ins[5:0];
      imm_d   = '0;
    end else if (zero_ext(op_d)) begin
      imm_d   = {{(DATA_W-16){1'b0}}, ins[15:0]};
    end
  end

  // A load still in ID/EX cannot feed the instruction now waiting in ID.
  assign hazard   = out_valid && mem_rd && dest != '0 &&
                    (dest == rs_a || (dest == rt_a && uses_rt(op_d)));
  assign in_ready = !rst && !flush && !hazard && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // NOTE: pipeline state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      rdata1    <= '0;
      rdata2    <= '0;
      imm       <= '0;
      dest      <= '0;
      funct     <= '0;
      shamt     <= '0;
      op        <= '0;
      mem_rd    <= 1'b0;
      reg_we    <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      rdata1    <= rs_val;
      rdata2    <= rt_val;
      imm       <= imm_d;
      dest      <= dest_d;
      funct     <= funct_d;
      shamt     <= ins[10:6];
      op        <= op_d;
      mem_rd    <= (op_d == LW);
      reg_we    <= (dest_d != '0) && !no_writeback(op_d);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed self-checking bench for id_stage_pipe with hand-computed expectations.
module tb_id_stage_pipe;
  import id_stage_pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, flush;
  logic [31:0] ins;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid, out_ready;
  logic [31:0] rdata1, rdata2, imm;
  logic [4:0]  dest, shamt;
  logic [5:0]  funct, op;
  logic        mem_rd, reg_we;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  id_stage_pipe #(.DATA_W(32), .REG_N(32), .BYPASS_EN(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ins       (ins),
    .flush     (flush),
    .wb_we     (wb_we),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rdata1    (rdata1),
    .rdata2    (rdata2),
    .imm       (imm),
    .dest      (dest),
    .funct     (funct),
    .shamt     (shamt),
    .op        (op),
    .mem_rd    (mem_rd),
    .reg_we    (reg_we)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rform(input int rs, rt, rd, sh, input logic [5:0] fn);
    return {R_FORM, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
  endfunction

  function automatic logic [31:0] iform(input logic [5:0] opc, input int rs, rt, input logic [15:0] im);
    return {opc, 5'(rs), 5'(rt), im};
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b1; flush = 1'b0; out_ready = 1'b1;
    ins = rform(1, 2, 3, 4, ADD); wb_we = 1'b0; wb_addr = '0; wb_data = '0;

    // 1 reset
    repeat (3) tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_rdata1", rdata1, 32'd0);
    check("rst_dest", 32'(dest), 32'd0);
    check("rst_funct", 32'(funct), 32'd0);
    rst = 1'b0; in_valid = 1'b0;

    // 2 R-form after preloading r10=7, r11=9
    wb_we = 1'b1; wb_addr = 5'd10; wb_data = 32'd7; tick();
    wb_addr = 5'd11; wb_data = 32'd9; tick();
    wb_we = 1'b0;
    ins = rform(10, 11, 9, 5, SLT); in_valid = 1'b1; #1;
    check("r_in_ready", 32'(in_ready), 32'd1);
    tick(); in_valid = 1'b0;
    check("r_out_valid", 32'(out_valid), 32'd1);
    check("r_rdata1", rdata1, 32'd7);
    check("r_rdata2", rdata2, 32'd9);
    check("r_dest", 32'(dest), 32'd9);
    check("r_shamt", 32'(shamt), 32'd5);
    check("r_funct", 32'(funct), 32'(SLT));
    check("r_reg_we", 32'(reg_we), 32'd1);
    check("r_imm", imm, 32'd0);
    tick();
    check("r_drained", 32'(out_valid), 32'd0);

    // 3 bypass on r8, then writes to r0 are never visible
    ins = iform(ADDI, 8, 3, 16'h0001); in_valid = 1'b1;
    wb_we = 1'b1; wb_addr = 5'd8; wb_data = 32'h1234;
    tick();
    check("byp_rdata1", rdata1, 32'h1234);
    check("byp_dest", 32'(dest), 32'd3);
    check("byp_imm", imm, 32'd1);
    ins = rform(0, 8, 2, 0, ADD); wb_addr = 5'd0; wb_data = 32'd5;
    tick(); wb_we = 1'b0;
    check("r0_same_cycle", rdata1, 32'd0);
    check("r8_stored", rdata2, 32'h1234);
    tick();
    check("r0_later", rdata1, 32'd0);
    in_valid = 1'b0; tick();

    // 4 back-pressure
    ins = rform(10, 11, 12, 0, AND); in_valid = 1'b1; out_ready = 1'b0;
    tick();
    ins = rform(11, 10, 13, 0, OR);
    for (int i = 0; i < 4; i++) begin
      check("bp_in_ready", 32'(in_ready), 32'd0);
      tick();
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_dest", 32'(dest), 32'd12);
      check("bp_funct", 32'(funct), 32'(AND));
    end
    out_ready = 1'b1; #1;
    check("bp_release_ready", 32'(in_ready), 32'd1);
    tick(); in_valid = 1'b0;
    check("bp_next_dest", 32'(dest), 32'd13);
    check("bp_next_rdata1", rdata1, 32'd9);
    check("bp_next_rdata2", rdata2, 32'd7);
    tick();
    check("bp_no_dup", 32'(out_valid), 32'd0);

    // 5 load-use: exactly one bubble
    ins = iform(LW, 0, 4, 16'h0010); in_valid = 1'b1;
    tick();
    check("lw_mem_rd", 32'(mem_rd), 32'd1);
    check("lw_dest", 32'(dest), 32'd4);
    ins = rform(4, 10, 6, 0, ADD); #1;
    check("lu_in_ready", 32'(in_ready), 32'd0);
    tick();
    check("lu_bubble", 32'(out_valid), 32'd0);
    check("lu_ready_after", 32'(in_ready), 32'd1);
    tick(); in_valid = 1'b0;
    check("lu_issue_valid", 32'(out_valid), 32'd1);
    check("lu_issue_dest", 32'(dest), 32'd6);
    check("lu_issue_rdata2", rdata2, 32'd7);
    tick();
    check("lu_once", 32'(out_valid), 32'd0);

    // LW then an I-form that only writes rt=4: no hazard; ADDI sign-extends
    ins = iform(LW, 0, 4, 16'h0010); in_valid = 1'b1; tick();
    ins = iform(ADDI, 1, 4, 16'hFFFF); #1;
    check("nohaz_in_ready", 32'(in_ready), 32'd1);
    tick();
    check("addi_imm", imm, 32'hFFFF_FFFF);
    check("addi_mem_rd", 32'(mem_rd), 32'd0);

    // 6 flush while stalled, then ORI zero-extends, SW does not write back
    out_ready = 1'b0; flush = 1'b1; ins = iform(ORI, 0, 5, 16'hFFFF); #1;
    check("fl_in_ready", 32'(in_ready), 32'd0);
    tick();
    check("fl_out_valid", 32'(out_valid), 32'd0);
    flush = 1'b0; out_ready = 1'b1;
    tick();
    check("ori_imm", imm, 32'h0000_FFFF);
    check("ori_dest", 32'(dest), 32'd5);
    ins = iform(SW, 1, 7, 16'h0004);
    tick();
    check("sw_reg_we", 32'(reg_we), 32'd0);
    check("sw_imm", imm, 32'd4);

    // async reset mid-cycle drops the entry; first accept on the edge after release
    #2 rst = 1'b1; #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_ready", 32'(in_ready), 32'd0);
    tick(); rst = 1'b0;
    ins = rform(10, 11, 14, 0, SUB);
    tick(); in_valid = 1'b0;
    check("arst_first_valid", 32'(out_valid), 32'd1);
    check("arst_first_rdata1", rdata1, 32'd0);
    check("arst_first_dest", 32'(dest), 32'd14);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
